// File: rtl/vector_store_unit.sv
// vector_store_unit
// Snapshots the four lanes of the output vector register plus a base address
// on start, then writes the lanes to data memory one word per accepted cycle
// at consecutive strided addresses, honouring the memory ready handshake.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   request a 4-lane store (sampled only in IDLE)
//   base_addr               address of lane 0, captured with start
//   data1..data4            lanes 0..3, captured with start
//   mem_ready               memory accepts the current write this cycle
//   mem_we/mem_addr/mem_wdata  write request, address, data
//   busy                    high while writing and during the done cycle
//   done                    single-cycle completion pulse
module vector_store_unit #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned ADDR_STEP = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [DATA_W-1:0] data1,
   input  logic [DATA_W-1:0] data2,
   input  logic [DATA_W-1:0] data3,
   input  logic [DATA_W-1:0] data4,
   input  logic              mem_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              busy,
   output logic              done
);

   localparam int unsigned NUM_LANES = 4;
   localparam int unsigned IDX_W     = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  lane_q [NUM_LANES];
   logic               capture;

   // State, index, address and lane snapshot registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         addr_q  <= '0;
         for (int i = 0; i < NUM_LANES; i++) lane_q[i] <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         if (capture) begin
            lane_q[0] <= data1;
            lane_q[1] <= data2;
            lane_q[2] <= data3;
            lane_q[3] <= data4;
         end
      end
   end

   // Next-state and output decode; write outputs are zero outside WRITE
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      addr_d    = addr_q;
      capture   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      busy      = 1'b0;
      done      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               capture = 1'b1;
               addr_d  = base_addr;
               idx_d   = '0;
               state_d = WRITE;
            end
         end
         WRITE: begin
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = lane_q[idx_q];
            busy      = 1'b1;
            if (mem_ready) begin
               if (idx_q == IDX_W'(NUM_LANES - 1)) begin
                  state_d = DONE;
               end else begin
                  idx_d  = idx_q + IDX_W'(1);
                  // Wraps silently modulo 2^ADDR_W
                  addr_d = addr_q + ADDR_W'(ADDR_STEP);
               end
            end
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_vector_store_unit.sv
// Self-checking bench for vector_store_unit: a scoreboard queue of expected
// (addr, data) writes is filled when a store is started and drained by a
// monitor on every accepted write; scenario tasks check timing and handshakes.
module tb_vector_store_unit;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [DATA_W-1:0] data1, data2, data3, data4;
   logic              mem_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              busy;
   logic              done;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;

   wr_t         sb [$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] stall_mask = '0;
   logic [15:0] noise_mask = '0;

   vector_store_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ADDR_STEP(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .data1     (data1),
      .data2     (data2),
      .data3     (data3),
      .data4     (data4),
      .mem_ready (mem_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: every accepted write must match the next expected one
   always @(negedge clk) begin : monitor
      wr_t e;
      if (rst_n === 1'b1 && mem_we === 1'b1 && mem_ready === 1'b1) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", mem_addr, mem_wdata);
         end else begin
            e = sb.pop_front();
            if (mem_addr !== e.addr || mem_wdata !== e.data) begin
               n_fail++;
               $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                        mem_addr, mem_wdata, e.addr, e.data);
            end
         end
      end
   end

   // Drive one start pulse and queue the four expected writes
   task automatic start_op(input logic [31:0] base, input logic [31:0] d0,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
      logic [ADDR_W-1:0] a;
      @(posedge clk); #1;
      base_addr = base; data1 = d0; data2 = d1; data3 = d2; data4 = d3;
      start = 1'b1;
      a = base;
      sb.push_back({a, d0}); a = a + 32'd4;
      sb.push_back({a, d1}); a = a + 32'd4;
      sb.push_back({a, d2}); a = a + 32'd4;
      sb.push_back({a, d3});
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Run cycles after the start edge until done has pulsed and busy has dropped
   task automatic wait_done(output int done_cyc, output int done_cnt, output int busy_cnt,
                            output int stall_cnt, output logic [31:0] stall_addr,
                            output logic [31:0] stall_data, output bit stall_stable,
                            output bit timed_out);
      done_cyc = 0; done_cnt = 0; busy_cnt = 0; stall_cnt = 0;
      stall_addr = '0; stall_data = '0; stall_stable = 1'b1; timed_out = 1'b1;
      for (int cyc = 1; cyc < 16; cyc++) begin
         mem_ready = ~stall_mask[cyc];
         if (noise_mask[cyc]) begin
            start = 1'b1;
            data1 = $urandom; data2 = $urandom; data3 = $urandom; data4 = $urandom;
            base_addr = $urandom;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
         if (mem_we === 1'b1 && mem_ready === 1'b0) begin
            if (stall_cnt == 0) begin
               stall_addr = mem_addr; stall_data = mem_wdata;
            end else if (mem_addr !== stall_addr || mem_wdata !== stall_data) begin
               stall_stable = 1'b0;
            end
            stall_cnt++;
         end
         if (done_cnt > 0 && busy === 1'b0) begin
            timed_out = 1'b0;
            break;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      mem_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; mem_ready = 1'b1; base_addr = '0;
      data1 = '0; data2 = '0; data3 = '0; data4 = '0;
      #2;
      n_checks++;
      if ({mem_we, busy, done} !== 3'b000 || mem_addr !== '0 || mem_wdata !== '0) begin
         n_fail++;
         $display("FAIL reset_initial: got we/busy/done=%b addr=%h data=%h, expected 000/0/0",
                  {mem_we, busy, done}, mem_addr, mem_wdata);
      end
      @(negedge clk); rst_n = 1'b1;

      // Abort mid-WRITE: lanes 0,1 accepted, reset lands between edges in lane 2
      start_op(32'h200, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
      mem_ready = 1'b1;
      @(posedge clk); @(posedge clk); #3;
      n_checks++;
      if (mem_we !== 1'b1 || mem_addr !== 32'h208) begin
         n_fail++;
         $display("FAIL reset_pre_abort: got we=%b addr=%h, expected we=1 addr=00000208", mem_we, mem_addr);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({mem_we, busy, done} !== 3'b000 || mem_addr !== '0 || mem_wdata !== '0) begin
         n_fail++;
         $display("FAIL reset_async: got we/busy/done=%b addr=%h data=%h, expected 000/0/0",
                  {mem_we, busy, done}, mem_addr, mem_wdata);
      end
      n_checks++;
      if (sb.size() != 2) begin
         n_fail++;
         $display("FAIL reset_lanes_written: got %0d pending, expected 2", sb.size());
      end
      sb.delete();
      @(posedge clk); @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({mem_we, busy, done} !== 3'b000 || mem_addr !== '0 || mem_wdata !== '0) begin
         n_fail++;
         $display("FAIL reset_release: got we/busy/done=%b addr=%h data=%h, expected 000/0/0",
                  {mem_we, busy, done}, mem_addr, mem_wdata);
      end
   endtask

   task automatic test_basic();
      int dc, dn, bc, sc; logic [31:0] sa, sd; bit ss, to;
      stall_mask = '0; noise_mask = '0;
      start_op(32'h100, 32'h11, 32'h22, 32'h33, 32'h44);
      wait_done(dc, dn, bc, sc, sa, sd, ss, to);
      n_checks++;
      if (to || dc != 5 || dn != 1 || bc != 5) begin
         n_fail++;
         $display("FAIL basic_timing: got timeout=%0d done_cyc=%0d done_cnt=%0d busy=%0d, expected 0/5/1/5",
                  to, dc, dn, bc);
      end
   endtask

   task automatic test_backpressure();
      int dc, dn, bc, sc; logic [31:0] sa, sd; bit ss, to;
      stall_mask = 16'h0018; noise_mask = '0;
      start_op(32'h100, 32'h11, 32'h22, 32'h33, 32'h44);
      wait_done(dc, dn, bc, sc, sa, sd, ss, to);
      stall_mask = '0;
      n_checks++;
      if (to || dc != 7 || dn != 1 || bc != 7) begin
         n_fail++;
         $display("FAIL bp_timing: got timeout=%0d done_cyc=%0d done_cnt=%0d busy=%0d, expected 0/7/1/7",
                  to, dc, dn, bc);
      end
      n_checks++;
      if (sc != 2 || sa !== 32'h108 || sd !== 32'h33 || !ss) begin
         n_fail++;
         $display("FAIL bp_hold: got stalls=%0d addr=%h data=%h stable=%0d, expected 2/00000108/00000033/1",
                  sc, sa, sd, ss);
      end
   endtask

   task automatic test_wrap();
      int dc, dn, bc, sc; logic [31:0] sa, sd; bit ss, to;
      stall_mask = '0; noise_mask = '0;
      start_op(32'hFFFF_FFF8, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003, 32'hDEAD_0004);
      wait_done(dc, dn, bc, sc, sa, sd, ss, to);
      n_checks++;
      if (to || dc != 5 || dn != 1) begin
         n_fail++;
         $display("FAIL wrap_timing: got timeout=%0d done_cyc=%0d done_cnt=%0d, expected 0/5/1", to, dc, dn);
      end
   endtask

   task automatic test_snapshot();
      int dc, dn, bc, sc; logic [31:0] sa, sd; bit ss, to;
      stall_mask = '0;
      noise_mask = 16'h0026;   // start + new data in WRITE cycles 1,2 and the DONE cycle
      start_op(32'h4000, 32'hCAFE_0000, 32'hCAFE_1111, 32'hCAFE_2222, 32'hCAFE_3333);
      wait_done(dc, dn, bc, sc, sa, sd, ss, to);
      noise_mask = '0;
      n_checks++;
      if (to || dc != 5 || dn != 1 || bc != 5) begin
         n_fail++;
         $display("FAIL snap_timing: got timeout=%0d done_cyc=%0d done_cnt=%0d busy=%0d, expected 0/5/1/5",
                  to, dc, dn, bc);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (mem_we !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL snap_no_restart: got we=%b busy=%b, expected 0/0", mem_we, busy);
         end
      end
      start_op(32'h5000, 32'h1, 32'h2, 32'h3, 32'h4);
      wait_done(dc, dn, bc, sc, sa, sd, ss, to);
      n_checks++;
      if (to || dc != 5 || dn != 1) begin
         n_fail++;
         $display("FAIL snap_followup: got timeout=%0d done_cyc=%0d done_cnt=%0d, expected 0/5/1", to, dc, dn);
      end
   endtask

   task automatic test_back_to_back();
      int dc, dn, bc, sc; logic [31:0] sa, sd; bit ss, to;
      stall_mask = 16'h0002; noise_mask = '0;
      start_op(32'h0, 32'h5555_5555, 32'hAAAA_AAAA, 32'h0, 32'hFFFF_FFFF);
      wait_done(dc, dn, bc, sc, sa, sd, ss, to);
      stall_mask = '0;
      n_checks++;
      if (to || dc != 6 || dn != 1 || bc != 6) begin
         n_fail++;
         $display("FAIL b2b_timing: got timeout=%0d done_cyc=%0d done_cnt=%0d busy=%0d, expected 0/6/1/6",
                  to, dc, dn, bc);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_snapshot();
      test_back_to_back();
      repeat (3) @(posedge clk);
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending writes, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
